hazard_unit_mc: RTL and testbench

Next-generation pipeline hazard unit for the 5-stage MIPS core. It adds 2-bit E-stage forwarding selects, load-use and branch-compare stalls, and a sequential scoreboard for one multi-cycle multiply/divide unit. The scoreboard holds a countdown of `MUL_LAT` cycles and stalls dependent or structurally conflicting instructions in D until the result is written. The block sits beside the datapath and drives the F/D stall enables, the E flush and all forwarding muxes.

---
 rtl/hazard_unit_mc.sv | 129 ++++++++++++
 tb/tb_hazard_unit_mc.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: E/D forwarding, load-use/branch/multi-cycle stalls and a
// countdown scoreboard for one multi-cycle unit. Optional stall counter under HAZARD_PERF_EN.
module hazard_unit_mc #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MUL_LAT    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BranchD,
    input  logic                  JumpD,
    input  logic                  MulD,
    input  logic [REG_ADDR_W-1:0] RsD,
    input  logic [REG_ADDR_W-1:0] RtD,
    input  logic [REG_ADDR_W-1:0] RsE,
    input  logic [REG_ADDR_W-1:0] RtE,
    input  logic [REG_ADDR_W-1:0] WriteRegE,
    input  logic                  RegWriteE,
    input  logic                  MemtoRegE,
    input  logic                  MulStartE,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic [REG_ADDR_W-1:0] WriteRegW,
    input  logic                  RegWriteW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  ForwardAD,
    output logic                  ForwardBD,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushE,
    output logic                  MulBusy,
    output logic                  MulWbW,
    output logic [REG_ADDR_W-1:0] MulDest
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           StallCount
`endif
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] mul_dest_q, mul_dest_d;
    logic [1:0]            fwd_ae, fwd_be;
    logic                  busy, lwstall, brstall, mulstall, stall_any;
    logic                  unused_jump;

    // Jumps resolve in D without reading registers, so they never stall.
    assign unused_jump = JumpD;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] a,
                                     input logic [REG_ADDR_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (RegWriteM && reg_hit(src, WriteRegM)) begin
            sel = 2'b10;
        end else if (RegWriteW && reg_hit(src, WriteRegW)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign fwd_ae = fwd_sel(RsE);
    assign fwd_be = fwd_sel(RtE);

    assign busy     = (cnt_q != '0);
    assign lwstall  = MemtoRegE && (reg_hit(RsD, WriteRegE) || reg_hit(RtD, WriteRegE));
    assign brstall  = BranchD &&
                      ((RegWriteE && (reg_hit(RsD, WriteRegE) || reg_hit(RtD, WriteRegE))) ||
                       (MemtoRegM && (reg_hit(RsD, WriteRegM) || reg_hit(RtD, WriteRegM))));
    assign mulstall = busy && (reg_hit(RsD, mul_dest_q) || reg_hit(RtD, mul_dest_q) || MulD);
    assign stall_any = lwstall || brstall || mulstall;

    // All outputs are held at zero while reset is asserted.
    assign ForwardAE = RST ? 2'b00 : fwd_ae;
    assign ForwardBE = RST ? 2'b00 : fwd_be;
    assign ForwardAD = !RST && RegWriteM && reg_hit(RsD, WriteRegM);
    assign ForwardBD = !RST && RegWriteM && reg_hit(RtD, WriteRegM);
    assign StallF    = !RST && stall_any;
    assign StallD    = !RST && stall_any;
    assign FlushE    = !RST && stall_any;
    assign MulBusy   = !RST && busy;
    assign MulWbW    = !RST && (cnt_q == CNT_W'(1));
    assign MulDest   = RST ? '0 : mul_dest_q;

    // Scoreboard next state: a start is only honoured when the unit is idle.
    always_comb begin
        cnt_d      = cnt_q;
        mul_dest_d = mul_dest_q;
        if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (MulStartE) begin
            cnt_d      = CNT_W'(MUL_LAT);
            mul_dest_d = WriteRegE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q      <= '0;
            mul_dest_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            mul_dest_q <= mul_dest_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count_q;

    // Saturating count of stalled cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_count_q <= '0;
        end else if (stall_any && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign StallCount = RST ? 32'd0 : stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: expected output sets are queued per cycle
// and compared at the falling edge of that cycle.
module tb_hazard_unit_mc;

    localparam int unsigned AW = 5;

    logic          CLK, RST;
    logic          BranchD, JumpD, MulD;
    logic [AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic          RegWriteE, MemtoRegE, MulStartE, RegWriteM, MemtoRegM, RegWriteW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          ForwardAD, ForwardBD, StallF, StallD, FlushE, MulBusy, MulWbW;
    logic [AW-1:0] MulDest;
`ifdef HAZARD_PERF_EN
    logic [31:0]   StallCount;
`endif

    hazard_unit_mc #(.REG_ADDR_W(AW), .MUL_LAT(4)) dut (
        .CLK(CLK), .RST(RST),
        .BranchD(BranchD), .JumpD(JumpD), .MulD(MulD),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MulStartE(MulStartE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .MulBusy(MulBusy), .MulWbW(MulWbW), .MulDest(MulDest)
`ifdef HAZARD_PERF_EN
        , .StallCount(StallCount)
`endif
    );

    typedef struct {
        logic [1:0]    fae, fbe;
        logic          fad, fbd, stall, busy, wb;
        logic [AW-1:0] dest;
        logic          chk_sc;
        logic [31:0]   sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // First edge is a falling one so each cycle's expectations are checked before its rising edge.
    initial begin
        CLK = 1'b1;
        forever #5 CLK = ~CLK;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else n_pass++;
    endtask

    function automatic exp_t mk(input logic [1:0] fae, input logic [1:0] fbe,
                                input logic fad, input logic fbd, input logic stall,
                                input logic busy, input logic wb, input logic [AW-1:0] dest);
        exp_t e;
        e.fae = fae; e.fbe = fbe; e.fad = fad; e.fbd = fbd; e.stall = stall;
        e.busy = busy; e.wb = wb; e.dest = dest; e.chk_sc = 1'b0; e.sc = 32'd0;
        return e;
    endfunction

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("ForwardAE", 32'(ForwardAE), 32'(e.fae));
            check_val("ForwardBE", 32'(ForwardBE), 32'(e.fbe));
            check_val("ForwardAD", 32'(ForwardAD), 32'(e.fad));
            check_val("ForwardBD", 32'(ForwardBD), 32'(e.fbd));
            check_val("StallF",    32'(StallF),    32'(e.stall));
            check_val("StallD",    32'(StallD),    32'(e.stall));
            check_val("FlushE",    32'(FlushE),    32'(e.stall));
            check_val("MulBusy",   32'(MulBusy),   32'(e.busy));
            check_val("MulWbW",    32'(MulWbW),    32'(e.wb));
            check_val("MulDest",   32'(MulDest),   32'(e.dest));
`ifdef HAZARD_PERF_EN
            if (e.chk_sc) check_val("StallCount", StallCount, e.sc);
`endif
        end
    end

    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        BranchD = 0; JumpD = 0; MulD = 0;
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; RegWriteE = 0; MemtoRegE = 0; MulStartE = 0;
        WriteRegM = '0; RegWriteM = 0; MemtoRegM = 0;
        WriteRegW = '0; RegWriteW = 0;
    endtask

    initial begin
        exp_t e;
        clear_inputs();
        // Reset: outputs forced low even with live hazards and a start request.
        RST = 1;
        RegWriteM = 1; WriteRegM = 8; RsE = 8; RsD = 8; MulStartE = 1; WriteRegE = 5;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0); e.chk_sc = 1; e.sc = 0;
        step(e);
        RST = 0;
        clear_inputs();

        // M/W forwarding priority
        RegWriteM = 1; WriteRegM = 8; RegWriteW = 1; WriteRegW = 8; RsE = 8;
        step(mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0));
        RegWriteM = 0;
        step(mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        RsE = 0; RtE = 8;
        step(mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0));
        clear_inputs();

        // Load-use for exactly one cycle, then register 0 never matches
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 9; RtD = 9;
        step(mk(0, 0, 0, 0, 1, 0, 0, 0));
        MemtoRegE = 0;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0));
        MemtoRegE = 1; WriteRegE = 0; RtD = 0; RsD = 0;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0));
        clear_inputs();

        // Branch compare stalls on E writer, then forwards from M
        BranchD = 1; RegWriteE = 1; WriteRegE = 4; RsD = 4;
        step(mk(0, 0, 0, 0, 1, 0, 0, 0));
        RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 4;
        step(mk(0, 0, 1, 0, 0, 0, 0, 0));
        MemtoRegM = 1;
        step(mk(0, 0, 1, 0, 1, 0, 0, 0));
        BranchD = 0; JumpD = 1;
        step(mk(0, 0, 1, 0, 0, 0, 0, 0));
        clear_inputs();

        // Multi-cycle dependency: start at edge 0, dependent RsD held
        MulStartE = 1; RegWriteE = 1; WriteRegE = 10; RsD = 10;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0));
        MulStartE = 0; RegWriteE = 0; WriteRegE = 0;
        step(mk(0, 0, 0, 0, 1, 1, 0, 10));
        step(mk(0, 0, 0, 0, 1, 1, 0, 10));
        step(mk(0, 0, 0, 0, 1, 1, 0, 10));
        // Start request in the write-back cycle must not reload
        MulStartE = 1; WriteRegE = 12;
        step(mk(0, 0, 0, 0, 1, 1, 1, 10));
        // Idle again: dependent advances and a new start is accepted
        WriteRegE = 11;
        e = mk(0, 0, 0, 0, 0, 0, 0, 10); e.chk_sc = 1; e.sc = 7;
        step(e);
        clear_inputs();

        // Structural conflict, then reset in the second busy cycle
        MulD = 1;
        step(mk(0, 0, 0, 0, 1, 1, 0, 11));
        MulD = 0; RST = 1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0));
        RST = 0;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0); e.chk_sc = 1; e.sc = 0;
        step(e);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0));

        @(negedge CLK);
        if (exp_q.size() != 0) check_val("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
